// File: rtl/decimal2hex_pkg.sv
// Shared constants for the secmer keypad/display datapath: converter FSM
// encodings, BCD digit limit and error flag positions.
package secmer_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    localparam int ERR_DIGIT = 0;
    localparam int ERR_RANGE = 1;

endpackage

// File: rtl/decimal2hex_mac_step.sv
// One decimal digit step: acc*10 + digit built from two shifts and an add,
// plus a flag for a nibble that is not a legal BCD digit.
module bcd_mac_step
    import secmer_defs::*;
#(
    parameter int AW = 12
) (
    input  logic [AW-1:0] acc,
    input  logic [3:0]    digit,
    output logic [AW-1:0] acc_next,
    output logic          digit_bad
);

    // acc*8 + acc*2 + digit; the caller sizes AW so this never wraps
    assign acc_next  = (acc << 3) + (acc << 1) + AW'(digit);
    assign digit_bad = (digit > BCD_DIGIT_MAX);

endmodule

// File: rtl/decimal2hex.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first,
// with valid/ready on both sides and digit/range error flags.
module decimal2hex
    import secmer_defs::*;
#(
    parameter int DIGITS = 3,
    parameter int W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] decimal,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        hex,
    output logic [1:0]          err
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    conv_state_t   state;
    conv_state_t   state_nx;

    logic [AW-1:0] shreg;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          digit_err;

    logic [AW-1:0] mac_acc;
    logic          mac_bad;

    logic          accept;
    logic          release_out;
    logic          last_digit;
    logic [1:0]    err_nx;
    logic [W-1:0]  hex_nx;

    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    assign last_digit  = (state == ST_CONV) && (cnt == '0);

    bcd_mac_step #(.AW(AW)) u_mac (
        .acc       (acc),
        .digit     (shreg[AW-1 -: 4]),
        .acc_next  (mac_acc),
        .digit_bad (mac_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)      state_nx = ST_CONV;
            ST_CONV: if (cnt == '0)   state_nx = ST_DONE;
            ST_DONE: if (release_out) state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Final flags come from the last MAC result, so DONE sees them registered
    always_comb begin
        err_nx            = '0;
        err_nx[ERR_DIGIT] = digit_err | mac_bad;
        err_nx[ERR_RANGE] = ((mac_acc >> W) != '0);
        hex_nx            = (err_nx != '0) ? '0 : W'(mac_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            digit_err <= 1'b0;
            hex       <= '0;
            err       <= '0;
        end else if (accept) begin
            shreg     <= decimal;
            acc       <= '0;
            cnt       <= CW'(DIGITS - 1);
            digit_err <= 1'b0;
            hex       <= '0;
            err       <= '0;
        end else if (state == ST_CONV) begin
            acc       <= mac_acc;
            shreg     <= shreg << 4;
            digit_err <= digit_err | mac_bad;
            cnt       <= cnt - 1'b1;
            if (last_digit) begin
                hex <= hex_nx;
                err <= err_nx;
            end
        end
    end

endmodule

// File: tb/tb_decimal2hex.sv
// Directed and randomized checks of decimal2hex against an arithmetic
// reference model of BCD-to-binary conversion.
module tb_decimal2hex;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] decimal;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  hex;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    decimal2hex #(.DIGITS(3), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decimal   (decimal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hex       (hex),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of the packed digits as plain decimal, bad nibbles still weighted
    function automatic void ref_conv(input logic [11:0] d, output logic [7:0] h,
                                     output logic [1:0] e);
        int v;
        bit bad;
        v   = 0;
        bad = 0;
        for (int i = 2; i >= 0; i--) begin
            int dg;
            dg = int'((d >> (4 * i)) & 12'hF);
            if (dg > 9) bad = 1;
            v = v * 10 + dg;
        end
        e = {(v > 255), bad};
        h = (e != 2'b00) ? 8'd0 : v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [11:0] d, input int stall, input string tag);
        int          lat;
        logic [7:0]  eh;
        logic [1:0]  ee;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " ready"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        decimal   = d;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        decimal  = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        ref_conv(d, eh, ee);
        check({tag, " latency"}, lat, 3);
        check({tag, " hex"}, hex, eh);
        check({tag, " err"}, err, ee);
        check({tag, " busy"}, in_ready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, " hold valid"}, out_valid, 1'b1);
            check({tag, " hold hex"}, hex, eh);
            check({tag, " hold err"}, err, ee);
            check({tag, " hold busy"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, out_valid, 1'b0);
        check({tag, " idle"}, in_ready, 1'b1);
    endtask

    initial begin
        int          acc_cyc[$];
        logic [7:0]  res[$];
        int          saw_ov;
        logic [11:0] rd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        decimal   = 12'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset hex", hex, 8'd0);
        check("reset err", err, 2'b00);

        run(12'h255, 0, "d255");
        run(12'h000, 0, "d000");
        run(12'h256, 0, "d256");
        run(12'h999, 0, "d999");
        run(12'h1A5, 0, "d1A5");
        run(12'hF99, 0, "dF99");
        run(12'h128, 4, "bp128");

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        decimal   = 12'h001;
        for (int c = 0; c < 16; c++) begin
            bit hs;
            bit ov;
            hs = in_valid && in_ready;
            ov = out_valid && out_ready;
            if (ov) res.push_back(hex);
            tick();
            if (hs) begin
                acc_cyc.push_back(c);
                if (acc_cyc.size() == 1) decimal = 12'h200;
                else                     in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b accepts", acc_cyc.size(), 2);
        check("b2b results", res.size(), 2);
        if (acc_cyc.size() == 2) check("b2b gap", acc_cyc[1] - acc_cyc[0], 5);
        if (res.size() == 2) begin
            check("b2b first", res[0], 8'd1);
            check("b2b second", res[1], 8'd200);
        end

        // Reset during the second CONV cycle drops the conversion
        out_ready = 1'b1;
        in_valid  = 1'b1;
        decimal   = 12'h077;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw_ov = 0;
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst hex", hex, 8'd0);
        check("rst err", err, 2'b00);
        for (int c = 0; c < 6; c++) begin
            if (out_valid) saw_ov++;
            tick();
        end
        check("rst no emit", saw_ov, 0);
        out_ready = 1'b0;
        run(12'h042, 0, "d042");

        // Randomized: mix of legal-only digits and arbitrary nibbles
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0)
                rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9))};
            else
                rd = 12'($urandom);
            run(rd, int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decimal2hex.md
# decimal2hex

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD value over a valid/ready handshake and returns its binary equivalent plus error flags. It processes one decimal digit per clock with a shift-and-add multiply-by-10, so it needs no multiplier. It sits on the input path of the secmer display/keypad datapath, opposite the binary-to-BCD display converter: user-entered decimal digits become 8-bit binary values.

## Interface
- `DIGITS`, 3: number of BCD digits in `decimal`.
- `W`, 8: binary output width; values above 2^W−1 are flagged as overflow.
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `in_valid` input 1: `decimal` is valid.
- `in_ready` output 1: converter can accept a value.
- `decimal` input 4*DIGITS: packed BCD, most significant digit at the top nibble.
- `out_valid` output 1: `hex` and `err` are valid.
- `out_ready` input 1: consumer accepts the result.
- `hex` output W: binary result. Forced to 0 when `err` ≠ 0.
- `err` output 2: bit0 means a digit is above 9; bit1 means the result exceeds 2^W−1.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - CONV: runs DIGITS cycles, from the most significant digit to the least.
  - DONE: `out_valid`=1.
- **IDLE → CONV** on `in_valid & in_ready`.
  - Capture `decimal` into a shift register.
  - Clear the accumulator and the error bits.
  - Load the digit counter with DIGITS−1.
- **Each CONV cycle:**
  - `acc <= (acc<<3) + (acc<<1) + digit`, where `digit` is the top nibble.
  - Shift the register left by 4.
  - Set `err[0]` if `digit > 9`. The digit value is still accumulated.
  - Decrement the counter.
- **CONV → DONE** after the cycle that processes counter value 0.
  - `err[1]` = (final acc > 2^W−1).
  - `hex` = err ? 0 : acc[W−1:0].
- **DONE → IDLE** on `out_valid & out_ready`.
- `hex` and `err` hold stable while `out_valid` is high and `out_ready` is low.
- **Accumulator width:** 4*DIGITS bits. 10^DIGITS < 16^DIGITS, so it never wraps internally. Overflow is detected only against W.
- **Reset:**
  - `rst` has priority over every handshake.
  - An input or output transfer on a cycle with `rst` high is discarded.
  - Reset mid-CONV or in DONE drops the conversion in progress. Nothing is emitted.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `hex`=0, `err`=0, accumulator 0.
- **Latency:** accept on edge E0 → `out_valid` high after edge E0+DIGITS (3 cycles by default).
- `in_ready` is 0 from the cycle after E0 until the edge that completes the output transfer.
- No bypass, so the minimum interval between accepts is DIGITS+2 cycles (5 by default).
- All outputs are registered or decoded directly from the state. There is no combinational path from input to output.
- `in_valid` may drop without being accepted; the converter needs no hold-while-valid guarantee from the producer.

## Structure
- **Shared constants header (`secmer_defs`):**
  - state encodings IDLE/CONV/DONE
  - `BCD_DIGIT_MAX` = 9
  - error bit indices `ERR_DIGIT` = 0, `ERR_RANGE` = 1
- **Sub-module `bcd_mac_step`** (combinational):
  - inputs: acc, digit
  - outputs: acc*10 + digit, `digit_bad` (digit > 9)
  - instantiated once, reused every CONV cycle
- The top level holds the FSM, counter, shift register, accumulator and output registers.

## Test plan
- **Normal value:** `decimal`=12'h255, `out_ready`=1 → `hex`=8'd255, `err`=0. `out_valid` rises 3 cycles after accept.
- **Zero and overflow:**
  - 12'h000 → `hex`=0, `err`=0.
  - 12'h256 → `err`=2'b10, `hex`=0.
  - 12'h999 → `err`=2'b10, `hex`=0.
- **Invalid digit:**
  - 12'h1A5 → `err`=2'b01, `hex`=0.
  - 12'hF99 → `err`=2'b11, `hex`=0.
- **Backpressure:** 12'h128 with `out_ready` low for 4 cycles → `hex`=8'd128 and `out_valid` held stable, `in_ready`=0 throughout. Transfer completes on the first high cycle, and `in_ready`=1 on the next cycle.
- **Back-to-back:** `in_valid` held high with 12'h001 then 12'h200, `out_ready`=1 → results 1 then 200. Accepts are exactly 5 cycles apart.
- **Reset mid-conversion:** assert `rst` for 1 cycle during the second CONV cycle of 12'h077 → no `out_valid` pulse. All outputs return to reset values. A following 12'h042 converts to 8'd42.
